multicycle_controller: RTL
==========================

# multicycle_controller

Control unit for the multicycle RV32I core. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. A combinational ALU decoder drives the `ALUControl` input of the ALU and consumes its `Zero` output for branch resolution. It sits directly upstream of the ALU and datapath muxes in the execute path.

## Interface
- No parameters; all encodings are fixed in `riscv_pkg`.
- `clk` in 1: core clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: instruction opcode, `Instr[6:0]` from the instruction register.
- `funct3` in 3: `Instr[14:12]`.
- `funct7b5` in 1: `Instr[30]`.
- `Zero` in 1: ALU zero flag.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = result.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction and OldPC register enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result mux. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1 data.
- `ALUSrcB` out 2: ALU B select. 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- `ImmSrc` out 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl` out 3: ALU operation code.
- `IllegalInstr` out 1: one-cycle pulse for an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ.
- Transitions:
  - FETCH→DECODE.
  - DECODE by `op`:
    - lw (0000011) and sw (0100011) → MEMADR.
    - R-type (0110011) → EXECUTER.
    - I-ALU (0010011) → EXECUTEI.
    - jal (1101111) → JAL.
    - beq (1100011) → BEQ.
    - Any other opcode → FETCH, with `IllegalInstr`=1 in that DECODE cycle.
  - MEMADR → MEMREAD if `op`=lw, otherwise MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER and EXECUTEI → ALUWB.
  - JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- Per-state outputs. Unlisted outputs are 0; ALUOp is internal.
  - FETCH: `AdrSrc`=0, `IRWrite`=1, `ALUSrcA`=00, `ALUSrcB`=10, ALUOp=00, `ResultSrc`=10, PCUpdate=1.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01, ALUOp=00 (branch/jump target precompute).
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, ALUOp=00.
  - MEMREAD: `ResultSrc`=00, `AdrSrc`=1.
  - MEMWRITE: `ResultSrc`=00, `AdrSrc`=1, `MemWrite`=1.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1.
  - EXECUTER: `ALUSrcA`=10, `ALUSrcB`=00, ALUOp=10.
  - EXECUTEI: `ALUSrcA`=10, `ALUSrcB`=01, ALUOp=10.
  - ALUWB: `ResultSrc`=00, `RegWrite`=1.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, ALUOp=00, `ResultSrc`=00, PCUpdate=1.
  - BEQ: `ALUSrcA`=10, `ALUSrcB`=00, ALUOp=01, `ResultSrc`=00, Branch=1.
- `PCWrite` = PCUpdate | (Branch & `Zero`).
- ALU decoder:
  - ALUOp 00 → ADD (000); ALUOp 01 → SUB (001).
  - ALUOp 10, by `funct3`:
    - 000 → SUB if `op[5]` & `funct7b5`, else ADD.
    - 010 → SLT (101).
    - 110 → OR (011).
    - 111 → AND (010).
    - Any other `funct3` → ADD.
- `ImmSrc` decodes from `op` in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.

## Timing
- Reset:
  - Async assert forces state to FETCH.
  - While `rst_n`=0, `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` and `IllegalInstr` are forced to 0.
  - The other outputs show FETCH values during reset.
- Reset mid-instruction abandons the instruction with no further writes. The first post-reset edge performs a FETCH.
- State register updates on the rising `clk` edge. All outputs except `PCWrite` are pure functions of state and instruction fields.
- `PCWrite` is combinational in `Zero` during BEQ. The `Zero` path must settle within the same cycle.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, illegal 2.
- `IRWrite` is high exactly one cycle per instruction, in FETCH.

## Structure
- `riscv_pkg` holds:
  - the `statetype` enum;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ);
  - `ALUControl` encodings: ALU_ADD 000, ALU_SUB 001, ALU_AND 010, ALU_OR 011, ALU_SLT 101;
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc select constants.
- Sub-module `alu_decoder` maps (ALUOp, funct3, op5, funct7b5) to `ALUControl`. The main FSM lives in `multicycle_controller`.

## Test plan
- **lw** (`op`=0000011) after reset release:
  - States FETCH→DECODE→MEMADR→MEMREAD→MEMWB→FETCH.
  - `RegWrite`=1 and `ResultSrc`=01 only in cycle 5.
  - `MemWrite` stays 0 throughout.
- **sub** (`op`=0110011, `funct3`=000, `funct7b5`=1):
  - `ALUControl`=001 in EXECUTER.
  - `RegWrite` in cycle 4.
  - With `funct7b5`=0, `ALUControl`=000.
- **I-ALU `funct7b5`, `funct3` and sw**:
  - I-ALU (`op`=0010011, `funct3`=000, `funct7b5`=1): `ALUControl`=000 (ADD), since `op[5]`=0.
  - `funct3`=010 gives 101; 110 gives 011; 111 gives 010.
  - sw: `MemWrite`=1 only in cycle 4, with `ImmSrc`=01.
- **beq**: in BEQ with `Zero`=1, `PCWrite`=1; with `Zero`=0, `PCWrite`=0. Both cases return to FETCH after 3 cycles.
- **jal**: `PCWrite`=1 in JAL. ALUWB then writes `RegWrite`=1 with `ResultSrc`=00. 4 cycles total, `ImmSrc`=11.
- **Illegal opcode and reset**:
  - `op`=1111111: `IllegalInstr` pulses for 1 cycle in DECODE, then FETCH with no register or memory write.
  - `rst_n` low asynchronously mid-MEMREAD: state is FETCH immediately, all write enables 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: op_supported = 1'b1;
            default:                                  op_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: turns the FSM's ALUOp plus instruction fields into the ALU
// operation code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    // Only R-type (op[5]=1) with funct7b5 selects SUB; addi never subtracts
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (i_funct3)
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core; write enables are held low
// while rst_n is asserted so an abandoned instruction can never commit.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalInstr
);

    statetype   r_state;
    logic [1:0] w_alu_op;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_illegal;

    // State sequencing; async reset parks the machine in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH: r_state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= MEMADR;
                        OP_R:         r_state <= EXECUTER;
                        OP_I:         r_state <= EXECUTEI;
                        OP_JAL:       r_state <= JAL;
                        OP_BEQ:       r_state <= BEQ;
                        default:      r_state <= FETCH;
                    endcase
                end
                MEMADR:   r_state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  r_state <= MEMWB;
                EXECUTER: r_state <= ALUWB;
                EXECUTEI: r_state <= ALUWB;
                JAL:      r_state <= ALUWB;
                MEMWB:    r_state <= FETCH;
                MEMWRITE: r_state <= FETCH;
                ALUWB:    r_state <= FETCH;
                BEQ:      r_state <= FETCH;
                default:  r_state <= FETCH;
            endcase
        end
    end

    // Per-state control decode
    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_illegal   = 1'b0;
        w_alu_op    = ALUOP_ADD;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        case (r_state)
            FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                w_illegal = ~op_supported(op);
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            MEMWB: begin
                ResultSrc   = RES_DATA;
                w_reg_write = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_RS2;
                w_alu_op = ALUOP_FUNC;
            end
            EXECUTEI: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNC;
            end
            ALUWB: begin
                w_reg_write = 1'b1;
            end
            JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            BEQ: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_RS2;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
            end
            default: begin
                w_illegal = 1'b0;
            end
        endcase
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        case (op)
            OP_LW, OP_I: ImmSrc = IMM_I;
            OP_SW:       ImmSrc = IMM_S;
            OP_BEQ:      ImmSrc = IMM_B;
            OP_JAL:      ImmSrc = IMM_J;
            default:     ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op5         (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (ALUControl)
    );

    assign PCWrite      = rst_n & (w_pc_update | (w_branch & Zero));
    assign IRWrite      = rst_n & w_ir_write;
    assign RegWrite     = rst_n & w_reg_write;
    assign MemWrite     = rst_n & w_mem_write;
    assign IllegalInstr = rst_n & w_illegal;

endmodule
